// File: rtl/isp_stat_pkg.sv
// Shared types and width helpers for the ISP statistics blocks.
package isp_stat_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int BLUE  = 2;

    function automatic int sum_width(input int dw, input int log2_max_pix);
        return dw + log2_max_pix;
    endfunction

    // Never narrower than one bit, even for a single-sample frame limit.
    function automatic int shift_width(input int log2_max_pix);
        return (log2_max_pix < 1) ? 1 : $clog2(log2_max_pix + 1);
    endfunction

endpackage

// File: rtl/channel_mean_acc_if.sv
// Tagged pixel stream with valid/ready handshake and frame markers.
interface channel_mean_acc_if #(
    parameter int NCH = 3,
    parameter int DW  = 8
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          valid_i;
    logic          ready_o;
    logic          sof_i;
    logic          last_i;
    logic [CW-1:0] color_i;
    logic [DW-1:0] value_i;

    modport master (output valid_i, sof_i, last_i, color_i, value_i, input ready_o);
    modport slave  (input valid_i, sof_i, last_i, color_i, value_i, output ready_o);

endinterface

// File: rtl/mean_round_shift.sv
// Combinational rounding right-shift of one channel sum, shift clamped, result saturated to DW.
module mean_round_shift #(
    parameter int DW     = 8,
    parameter int SUM_W  = 28,
    parameter int SW     = 5,
    parameter int MAX_SH = 20
) (
    input  logic [SUM_W-1:0] sum,
    input  logic [SW-1:0]    shift,
    output logic [DW-1:0]    mean
);

    function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] sh);
        return (sh > SW'(MAX_SH)) ? SW'(MAX_SH) : sh;
    endfunction

    // One extra bit keeps the rounding increment from wrapping a full sum.
    function automatic logic [SUM_W:0] round_shift(input logic [SUM_W-1:0] s,
                                                   input logic [SW-1:0] sh);
        logic [SUM_W:0] half;
        half = '0;
        if (sh != '0)
            half = (SUM_W+1)'(1) << (sh - 1'b1);
        return ({1'b0, s} + half) >> sh;
    endfunction

    function automatic logic [DW-1:0] sat_dw(input logic [SUM_W:0] v);
        return (v > (SUM_W+1)'({DW{1'b1}})) ? {DW{1'b1}} : v[DW-1:0];
    endfunction

    assign mean = sat_dw(round_shift(sum, clamp_shift(shift)));

endmodule

// File: rtl/channel_mean_acc.sv
// Per-frame, per-channel mean accumulator with frame error status.
// Optional CHANNEL_MEAN_MINMAX_EN adds per-channel min/max outputs.
module channel_mean_acc
    import isp_stat_pkg::*;
#(
    parameter int  NCH          = 3,
    parameter int  DW           = 8,
    parameter int  LOG2_MAX_PIX = 20,
    localparam int SW           = shift_width(LOG2_MAX_PIX)
) (
    input  logic                clk,
    input  logic                rst,
    channel_mean_acc_if.slave   pix,
    input  logic [NCH*SW-1:0]   shift_i,
    output logic [NCH*DW-1:0]   mean_o,
    output logic                mean_valid_o,
    output logic                err_o,
    output logic                busy_o
`ifdef CHANNEL_MEAN_MINMAX_EN
   ,output logic [NCH*DW-1:0]   min_o,
    output logic [NCH*DW-1:0]   max_o
`endif
);

    localparam int SUM_W = sum_width(DW, LOG2_MAX_PIX);
    localparam int CNT_W = LOG2_MAX_PIX + 1;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q [NCH];
    logic [SUM_W-1:0] sum_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [SW-1:0]    shift_q [NCH];
    logic [NCH-1:0]   hit, ovf_hit, mism;
    logic             ovf_q, ovf_d, bad_q, bad_d;
    logic             ready, accept, sof_beat, acc_en;
    logic [NCH*DW-1:0] mean_calc;

    // Returns {overflow, saturated sum}.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DW-1:0] v);
        logic [SUM_W:0] t;
        t = {1'b0, a} + (SUM_W+1)'(v);
        return t[SUM_W] ? {1'b1, {SUM_W{1'b1}}} : t;
    endfunction

    assign ready       = (state_q == IDLE) || (state_q == ACCUM);
    assign pix.ready_o = ready;
    assign busy_o      = (state_q != IDLE);
    assign accept      = pix.valid_i && ready;
    assign sof_beat    = accept && pix.sof_i;
    // Outside a frame only a sof beat contributes; other beats are dropped.
    assign acc_en      = accept && (pix.sof_i || (state_q == ACCUM));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sof_beat) state_d = pix.last_i ? CALC : ACCUM;
            ACCUM:   if (accept && pix.last_i) state_d = CALC;
            CALC:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulate stage: a sof beat restarts from cleared sums, counters and flags.
    always_comb begin
        hit     = '0;
        ovf_hit = '0;
        mism    = '0;
        for (int c = 0; c < NCH; c++) begin
            logic [SUM_W:0] add;
            sum_d[c] = sof_beat ? '0 : sum_q[c];
            cnt_d[c] = sof_beat ? '0 : cnt_q[c];
            hit[c]   = acc_en && (int'(pix.color_i) == c);
            add      = sat_add(sum_d[c], pix.value_i);
            if (hit[c]) begin
                sum_d[c]   = add[SUM_W-1:0];
                ovf_hit[c] = add[SUM_W];
                cnt_d[c]   = (&cnt_d[c]) ? cnt_d[c] : cnt_d[c] + 1'b1;
            end
            mism[c] = (shift_q[c] > SW'(LOG2_MAX_PIX)) ||
                      (cnt_q[c] != (CNT_W'(1) << shift_q[c]));
        end
        ovf_d = (sof_beat ? 1'b0 : ovf_q) | (|ovf_hit);
        bad_d = (sof_beat ? 1'b0 : bad_q) | (acc_en && !(|hit));
    end

    for (genvar g = 0; g < NCH; g++) begin : g_round
        mean_round_shift #(
            .DW(DW), .SUM_W(SUM_W), .SW(SW), .MAX_SH(LOG2_MAX_PIX)
        ) u_round (
            .sum   (sum_q[g]),
            .shift (shift_q[g]),
            .mean  (mean_calc[g*DW +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                sum_q[c]   <= '0;
                cnt_q[c]   <= '0;
                shift_q[c] <= '0;
            end
            ovf_q        <= 1'b0;
            bad_q        <= 1'b0;
            mean_o       <= '0;
            err_o        <= 1'b0;
            mean_valid_o <= 1'b0;
        end else begin
            mean_valid_o <= 1'b0;
            if (acc_en) begin
                for (int c = 0; c < NCH; c++) begin
                    sum_q[c] <= sum_d[c];
                    cnt_q[c] <= cnt_d[c];
                end
                ovf_q <= ovf_d;
                bad_q <= bad_d;
            end
            if (sof_beat)
                for (int c = 0; c < NCH; c++)
                    shift_q[c] <= shift_i[c*SW +: SW];
            // Output stage: results registered at the end of CALC.
            if (state_q == CALC) begin
                mean_o       <= mean_calc;
                err_o        <= ovf_q | bad_q | (|mism);
                mean_valid_o <= 1'b1;
            end
        end
    end

`ifdef CHANNEL_MEAN_MINMAX_EN
    logic [DW-1:0] min_q [NCH];
    logic [DW-1:0] max_q [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                min_q[c] <= '1;
                max_q[c] <= '0;
            end
            min_o <= '0;
            max_o <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (sof_beat) begin
                    min_q[c] <= hit[c] ? pix.value_i : '1;
                    max_q[c] <= hit[c] ? pix.value_i : '0;
                end else if (hit[c]) begin
                    if (pix.value_i < min_q[c]) min_q[c] <= pix.value_i;
                    if (pix.value_i > max_q[c]) max_q[c] <= pix.value_i;
                end
                if (state_q == CALC) begin
                    min_o[c*DW +: DW] <= (cnt_q[c] == '0) ? '0 : min_q[c];
                    max_o[c*DW +: DW] <= (cnt_q[c] == '0) ? '0 : max_q[c];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_channel_mean_acc.sv
// Directed bench for channel_mean_acc: main instance plus a narrow-accumulator instance.
module tb_channel_mean_acc;
    import isp_stat_pkg::*;

    logic        clk;
    logic        rst;
    logic [14:0] sha;
    logic [5:0]  shb;
    logic [23:0] mean_a, mean_b;
    logic        mv_a, mv_b, err_a, err_b, busy_a, busy_b;
`ifdef CHANNEL_MEAN_MINMAX_EN
    logic [23:0] min_a, max_a, min_b, max_b;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int p0;

    channel_mean_acc_if #(.NCH(3), .DW(8)) ifa ();
    channel_mean_acc_if #(.NCH(3), .DW(8)) ifb ();

    assign ifb.valid_i = ifa.valid_i;
    assign ifb.sof_i   = ifa.sof_i;
    assign ifb.last_i  = ifa.last_i;
    assign ifb.color_i = ifa.color_i;
    assign ifb.value_i = ifa.value_i;

    channel_mean_acc #(.NCH(3), .DW(8), .LOG2_MAX_PIX(20)) dut_a (
        .clk(clk), .rst(rst), .pix(ifa), .shift_i(sha),
        .mean_o(mean_a), .mean_valid_o(mv_a), .err_o(err_a), .busy_o(busy_a)
`ifdef CHANNEL_MEAN_MINMAX_EN
       ,.min_o(min_a), .max_o(max_a)
`endif
    );

    channel_mean_acc #(.NCH(3), .DW(8), .LOG2_MAX_PIX(2)) dut_b (
        .clk(clk), .rst(rst), .pix(ifb), .shift_i(shb),
        .mean_o(mean_b), .mean_valid_o(mv_b), .err_o(err_b), .busy_o(busy_b)
`ifdef CHANNEL_MEAN_MINMAX_EN
       ,.min_o(min_b), .max_o(max_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mv_a) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic l, input logic [1:0] c, input logic [7:0] v);
        logic acc;
        acc = 1'b0;
        ifa.valid_i = 1'b1;
        ifa.sof_i   = s;
        ifa.last_i  = l;
        ifa.color_i = c;
        ifa.value_i = v;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = ifa.ready_o;
            @(posedge clk); #1;
        end
        ifa.valid_i = 1'b0;
        ifa.sof_i   = 1'b0;
        ifa.last_i  = 1'b0;
        chk("beat_accept", 32'(acc), 32'd1);
    endtask

    // Called 1 ns after the edge that accepted the last beat.
    task automatic finish_frame(input string tag, input logic [23:0] m, input logic e);
        chk({tag, "_mv_T1"}, 32'(mv_a), 32'd0);
        chk({tag, "_ready_T1"}, 32'(ifa.ready_o), 32'd0);
        chk({tag, "_busy_T1"}, 32'(busy_a), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_mv_T2"}, 32'(mv_a), 32'd1);
        chk({tag, "_mean"}, 32'(mean_a), 32'(m));
        chk({tag, "_err"}, 32'(err_a), 32'(e));
        chk({tag, "_ready_T2"}, 32'(ifa.ready_o), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_mv_T3"}, 32'(mv_a), 32'd0);
        chk({tag, "_ready_T3"}, 32'(ifa.ready_o), 32'd1);
        chk({tag, "_busy_T3"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        logic [7:0] rv [4];
        logic [7:0] gv [4];
        rv = '{8'd1, 8'd1, 8'd1, 8'd2};
        gv = '{8'd1, 8'd2, 8'd2, 8'd2};
        rst = 1'b1;
        sha = {5'd2, 5'd2, 5'd2};
        shb = {2'd2, 2'd2, 2'd2};
        ifa.valid_i = 1'b0;
        ifa.sof_i   = 1'b0;
        ifa.last_i  = 1'b0;
        ifa.color_i = 2'(RED);
        ifa.value_i = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ifa.ready_o), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_mean", 32'(mean_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_mv", 32'(mv_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // R,G,B x4, values 10..120; valid held high through CALC/DONE.
        for (int i = 0; i < 12; i++)
            beat(i == 0, i == 11, 2'(i % 3), 8'((i + 1) * 10));
        ifa.valid_i = 1'b1;
        ifa.color_i = 2'(RED);
        ifa.value_i = 8'd200;
        finish_frame("basic", 24'h4B4137, 1'b0);
        ifa.valid_i = 1'b0;
        chk("basic_b_mean", 32'(mean_b), 32'h4B4137);
        chk("basic_b_err", 32'(err_b), 32'd0);

        // Blue gets only 3 samples against a shift of 2.
        for (int i = 0; i < 11; i++)
            beat(i == 0, i == 10, 2'(i % 3), 8'd8);
        finish_frame("mismatch", 24'h060808, 1'b1);

        // Red sum 5 -> 1, green sum 7 -> 2.
        for (int i = 0; i < 12; i++)
            beat(i == 0, i == 11, 2'(i % 3),
                 (i % 3 == 0) ? rv[i/3] : (i % 3 == 1) ? gv[i/3] : 8'd0);
        finish_frame("round", 24'h000201, 1'b0);

        // Tag 3 beat inserted mid-frame must not disturb the sums.
        for (int i = 0; i < 12; i++) begin
            beat(i == 0, i == 11, 2'(i % 3), 8'd12);
            if (i == 5) beat(1'b0, 1'b0, 2'd3, 8'd200);
        end
        finish_frame("badtag", 24'h0C0C0C, 1'b1);

        // Single sof+last beat with zero shifts: G and B counts are 0, not 1.
        sha = {5'd0, 5'd0, 5'd0};
        beat(1'b1, 1'b1, 2'(RED), 8'd77);
        finish_frame("soflast", 24'h00004D, 1'b1);

        // Aborted frame followed by a restart with new shifts.
        sha = {5'd2, 5'd2, 5'd2};
        p0 = pulses;
        for (int i = 0; i < 5; i++)
            beat(i == 0, 1'b0, 2'(RED), 8'd99);
        sha = {5'd0, 5'd1, 5'd1};
        beat(1'b1, 1'b0, 2'(RED), 8'd10);
        beat(1'b0, 1'b0, 2'(RED), 8'd13);
        beat(1'b0, 1'b0, 2'(GREEN), 8'd20);
        beat(1'b0, 1'b0, 2'(GREEN), 8'd21);
        beat(1'b0, 1'b1, 2'(BLUE), 8'd30);
        finish_frame("abort", 24'h1E150C, 1'b0);
        chk("abort_pulses", 32'(pulses - p0), 32'd1);

        // Reset in the middle of a frame.
        sha = {5'd2, 5'd2, 5'd2};
        p0 = pulses;
        beat(1'b1, 1'b0, 2'(RED), 8'd5);
        beat(1'b0, 1'b0, 2'(GREEN), 8'd6);
        beat(1'b0, 1'b0, 2'(BLUE), 8'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 32'(ifa.ready_o), 32'd1);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_mean", 32'(mean_a), 32'd0);
        chk("midrst_err", 32'(err_a), 32'd0);
        chk("midrst_mv", 32'(mv_a), 32'd0);
        beat(1'b0, 1'b1, 2'(RED), 8'd9);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_pulses", 32'(pulses - p0), 32'd0);
        chk("midrst_busy2", 32'(busy_a), 32'd0);

        // 8 x 255 on red: narrow instance clamps its sum at 1023.
        for (int i = 0; i < 8; i++)
            beat(i == 0, i == 7, 2'(RED), 8'd255);
        finish_frame("sat_a", 24'h0000FF, 1'b1);
        chk("sat_b_mean", 32'(mean_b), 32'h0000FF);
        chk("sat_b_err", 32'(err_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
